// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA font and colour constants
//
// Purpose: constants shared by the text-overlay engines and the font ROM
//          arbiter.
// Ports:   none (package).
package vga_pkg;

  // Font ROM geometry: address is {char[6:0], row[3:0]}, data is one 8-pixel glyph row.
  localparam int FONT_ADDR_W = 11;
  localparam int FONT_DATA_W = 8;

  // Colours used by the text engines.
  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] PINK  = 24'hF245C0;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
//
// Purpose: picks the first asserted request starting at ptr and wrapping
//          around, for use by VGA resource arbiters.
// Ports:
//   req       in   N_REQ          request vector
//   ptr       in   $clog2(N_REQ)  highest-priority index this cycle
//   grant     out  N_REQ          one-hot grant (all zero when no request)
//   winner    out  $clog2(N_REQ)  index of the granted request
//   any_grant out  1              at least one request is asserted
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] winner,
  output logic                     any_grant
);

  localparam int ID_W = $clog2(N_REQ);

  int idx;

  always_comb begin
    grant     = '0;
    winner    = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        winner     = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/font_rom_arbiter.sv
// rtl/font_rom_arbiter.sv - round-robin arbiter sharing one font ROM
//
// Purpose: grants one font ROM read per pixel clock among N_REQ text
//          engines, drives the ROM, tracks its latency and returns each
//          glyph row tagged with the requester id.
// Ports:
//   VGA_CLK_IN  in   1              pixel clock, all logic on posedge
//   reset       in   1              synchronous active-low reset
//   enable      in   1              1 = new grants allowed
//   req_valid   in   N_REQ          per-requester read request
//   req_addr    in   N_REQ*ADDR_W   flattened request addresses
//   req_ready   out  N_REQ          one-hot grant (combinational)
//   rom_en      out  1              registered ROM read strobe
//   rom_addr    out  ADDR_W         registered ROM address
//   rom_data    in   DATA_W         ROM read data
//   rsp_valid   out  1              registered response strobe
//   rsp_id      out  $clog2(N_REQ)  requester index of the response
//   rsp_data    out  DATA_W         glyph row data
module font_rom_arbiter
  import vga_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = FONT_ADDR_W,
  parameter int DATA_W  = FONT_DATA_W,
  parameter int ROM_LAT = 1
) (
  input  logic                     VGA_CLK_IN,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     rom_en,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [DATA_W-1:0]        rom_data,
  output logic                     rsp_valid,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [DATA_W-1:0]        rsp_data
);

  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0]  ptr;
  logic [N_REQ-1:0] pick_grant;
  logic [ID_W-1:0]  pick_id;
  logic             pick_any;
  logic             grant_fire;

  // Stage k holds the read issued k+1 cycles ago; stage ROM_LAT lines up
  // with valid rom_data.
  logic [ROM_LAT:0] pipe_v;
  logic [ID_W-1:0]  pipe_id [ROM_LAT:0];

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_rr_pick (
    .req      (req_valid),
    .ptr      (ptr),
    .grant    (pick_grant),
    .winner   (pick_id),
    .any_grant(pick_any)
  );

  // Reset gates the grant so nothing handshakes while the block is held.
  assign grant_fire = enable & reset & pick_any;
  assign req_ready  = grant_fire ? pick_grant : '0;

  always_ff @(posedge VGA_CLK_IN) begin
    if (!reset) begin
      ptr       <= '0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      pipe_v    <= '0;
      for (int k = 0; k <= ROM_LAT; k++) begin
        pipe_id[k] <= '0;
      end
    end else begin
      rom_en <= grant_fire;
      if (grant_fire) begin
        ptr      <= (pick_id == ID_W'(N_REQ - 1)) ? '0 : pick_id + ID_W'(1);
        rom_addr <= req_addr[pick_id*ADDR_W +: ADDR_W];
      end

      pipe_v[0]  <= grant_fire;
      pipe_id[0] <= pick_id;
      for (int k = 1; k <= ROM_LAT; k++) begin
        pipe_v[k]  <= pipe_v[k-1];
        pipe_id[k] <= pipe_id[k-1];
      end

      rsp_valid <= pipe_v[ROM_LAT];
      if (pipe_v[ROM_LAT]) begin
        rsp_id   <= pipe_id[ROM_LAT];
        rsp_data <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_font_rom_arbiter.sv
// tb/tb_font_rom_arbiter.sv - directed self-checking bench for font_rom_arbiter
module tb_font_rom_arbiter;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [3:0]  req_valid;
  logic [43:0] req_addr;
  logic [3:0]  req_ready;
  logic        rom_en;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;

  int n_pass  = 0;
  int n_total = 0;

  font_rom_arbiter #(
    .N_REQ(4), .ADDR_W(11), .DATA_W(8), .ROM_LAT(1)
  ) dut (
    .VGA_CLK_IN(clk),
    .reset     (reset),
    .enable    (enable),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(logic [10:0] a);
    return a[7:0] ^ 8'h86;
  endfunction

  // One-cycle-latency ROM model; returns a marker value when not enabled.
  always @(posedge clk) rom_data <= rom_en ? rom_fn(rom_addr) : 8'hEE;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_addr(input int i, input logic [10:0] a);
    req_addr[i*11 +: 11] = a;
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b1;
    req_valid = 4'hF;
    req_addr  = '0;
    for (int i = 0; i < 4; i++) set_addr(i, 11'h010 + 11'(i));

    // Reset held with all requests asserted.
    for (int c = 0; c < 3; c++) begin
      next_cycle(); settle();
      chk("rst_ready", req_ready, 4'b0000);
      chk("rst_rom_en", rom_en, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
    end
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);

    // Release into full contention for 8 cycles, then drain.
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      reset     = 1'b1;
      req_valid = (c < 8) ? 4'hF : 4'h0;
      settle();
      if (c < 8) chk("cont_ready", req_ready, 32'(1) << (c % 4));
      else       chk("cont_ready_idle", req_ready, 0);
      if (c >= 1 && c <= 8) begin
        chk("cont_rom_en", rom_en, 1);
        chk("cont_rom_addr", rom_addr, 11'h010 + 11'((c - 1) % 4));
      end
      if (c >= 3 && c <= 10) begin
        chk("cont_rsp_valid", rsp_valid, 1);
        chk("cont_rsp_id", rsp_id, (c - 3) % 4);
        chk("cont_rsp_data", rsp_data, rom_fn(11'h010 + 11'((c - 3) % 4)));
      end else begin
        chk("cont_rsp_idle", rsp_valid, 0);
      end
    end

    // Single read from requester 2.
    next_cycle();
    req_valid = 4'b0100;
    set_addr(2, 11'h123);
    settle();
    chk("single_ready", req_ready, 4'b0100);
    next_cycle();
    req_valid = 4'b0000;
    settle();
    chk("single_rom_en", rom_en, 1);
    chk("single_rom_addr", rom_addr, 11'h123);
    next_cycle(); settle();
    chk("single_rom_en_off", rom_en, 0);
    chk("single_rom_addr_hold", rom_addr, 11'h123);
    chk("single_rsp_early", rsp_valid, 0);
    next_cycle(); settle();
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_id", rsp_id, 2);
    chk("single_rsp_data", rsp_data, 8'hA5);
    next_cycle(); settle();
    chk("single_rsp_once", rsp_valid, 0);
    chk("single_rsp_hold", rsp_data, 8'hA5);

    // Pointer wrap: ptr=3 -> grant 1, then {0,3} alternate starting at 3.
    next_cycle(); req_valid = 4'b0010; settle();
    chk("wrap_g1", req_ready, 4'b0010);
    next_cycle(); req_valid = 4'b1001; settle();
    chk("wrap_g3a", req_ready, 4'b1000);
    next_cycle(); settle();
    chk("wrap_g0", req_ready, 4'b0001);
    next_cycle(); settle();
    chk("wrap_g3b", req_ready, 4'b1000);

    // Flush; ptr ends at 0.
    for (int c = 0; c < 3; c++) begin
      next_cycle(); req_valid = 4'b0000; settle();
    end

    // Enable hold-off.
    for (int i = 0; i < 4; i++) set_addr(i, 11'h040 + 11'(i));
    next_cycle(); req_valid = 4'hF; settle();
    chk("hold_grant", req_ready, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      next_cycle(); enable = 1'b0; settle();
      chk("hold_no_ready", req_ready, 0);
      chk("hold_rom_en", rom_en, (k == 0) ? 1 : 0);
      chk("hold_rsp_valid", rsp_valid, (k == 2) ? 1 : 0);
      if (k == 2) begin
        chk("hold_rsp_id", rsp_id, 0);
        chk("hold_rsp_data", rsp_data, rom_fn(11'h040));
      end
    end
    next_cycle(); enable = 1'b1; settle();
    chk("hold_resume", req_ready, 4'b0010);

    // Reset one cycle after a grant discards the read.
    next_cycle(); reset = 1'b0; req_valid = 4'b0000; settle();
    chk("mrst_ready", req_ready, 0);
    chk("mrst_rom_en_issued", rom_en, 1);
    next_cycle(); reset = 1'b1; settle();
    chk("mrst_rom_en", rom_en, 0);
    chk("mrst_rsp_id", rsp_id, 0);
    chk("mrst_rsp_data", rsp_data, 0);
    for (int c = 0; c < 3; c++) begin
      next_cycle(); settle();
      chk("mrst_no_rsp", rsp_valid, 0);
    end
    next_cycle(); req_valid = 4'hF; settle();
    chk("mrst_ptr0", req_ready, 4'b0001);

    // Single active requester granted every cycle.
    for (int c = 0; c < 3; c++) begin
      next_cycle(); req_valid = 4'b0100; settle();
      chk("solo_ready", req_ready, 4'b0100);
    end

    next_cycle(); req_valid = 4'b0000;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
